// File: rtl/skel_pkg.sv
// Shared definitions for the Zhang-Suen skeletonization engine: geometry, controller
// states and the 3x3 window layout used by both the controller and the centre mask.
package skel_pkg;
  localparam int N        = 8;
  localparam int NPIX     = N * N;
  localparam int BIT_SIZE = $clog2(NPIX);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SCAN1 = 3'd2,
    SCAN2 = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Window bit positions: P1 is the centre, P2..P9 run clockwise from north.
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int P3 = 2;
  localparam int P4 = 3;
  localparam int P5 = 4;
  localparam int P6 = 5;
  localparam int P7 = 6;
  localparam int P8 = 7;
  localparam int P9 = 8;

  // Row/column offset of each window bit relative to P1.
  localparam int NB_DR [9] = '{0, -1, -1, 0, 1, 1, 1, 0, -1};
  localparam int NB_DC [9] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
endpackage

// File: rtl/skel_main_controller_if.sv
// Host-side bundle of the skeletonization controller: image load stream, read-back
// port, status flags and a debug view of the controller state.
interface skel_main_controller_if;
  import skel_pkg::*;

  // we is a level-qualified stream with no ready: the controller always accepts, taking
  // one pixel per two-clock slot (second clock). rd_addr/rd_pixel is a combinational read.
  logic                we;
  logic [7:0]          data_in;
  logic [BIT_SIZE-1:0] rd_addr;
  logic                rd_pixel;
  logic                busy;
  logic                done;
  logic [7:0]          iter_cnt;
  state_t              dbg_state;

  modport master (
    output we, data_in, rd_addr,
    input  rd_pixel, busy, done, iter_cnt, dbg_state
  );

  modport slave (
    input  we, data_in, rd_addr,
    output rd_pixel, busy, done, iter_cnt, dbg_state
  );
endinterface

// File: rtl/skel_center_mask.sv
// Zhang-Suen deletion test for one 3x3 window: neighbour count B, 0->1 transition
// count A and the subiteration-specific product terms.
module skel_center_mask
  import skel_pkg::*;
(
  input  logic [8:0] win,
  input  logic       sub2,
  output logic       del
);
  logic [7:0] ring;
  logic [3:0] b_cnt;
  logic [3:0] a_cnt;
  logic       blocked;

  always_comb begin
    ring  = win[P9:P2];
    b_cnt = '0;
    a_cnt = '0;
    for (int k = 0; k < 8; k++) begin
      b_cnt = b_cnt + 4'(ring[k]);
      if (!ring[k] && ring[(k + 1) % 8]) a_cnt = a_cnt + 4'd1;
    end
  end

  assign blocked = sub2 ? ((win[P2] & win[P4] & win[P8]) | (win[P2] & win[P6] & win[P8]))
                        : ((win[P2] & win[P4] & win[P6]) | (win[P4] & win[P6] & win[P8]));

  assign del = win[P1] && (b_cnt >= 4'd2) && (b_cnt <= 4'd6) && (a_cnt == 4'd1) && !blocked;
endmodule

// File: rtl/skel_main_controller.sv
// Skeletonization controller: loads an NxN binary image, then runs Zhang-Suen passes
// over ping-pong image buffers until a whole pass deletes nothing.
module skel_main_controller
  import skel_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  skel_main_controller_if.slave bus
);
  localparam logic [BIT_SIZE:0] ADDR_END = (BIT_SIZE + 1)'(NPIX);

  state_t              state_q, state_d;
  logic [NPIX-1:0]     img0_q, img0_d, img1_q, img1_d;
  logic [NPIX-1:0]     cur_img;
  logic                buf_sel_q, buf_sel_d;
  logic                phase_q, phase_d;
  logic                chg_q, chg_d;
  logic [BIT_SIZE:0]   addr_q, addr_d;
  logic [7:0]          iter_q, iter_d;
  logic [BIT_SIZE-1:0] pix_addr;
  logic [8:0]          win;
  logic                del;

  assign cur_img  = buf_sel_q ? img1_q : img0_q;
  assign pix_addr = addr_q[BIT_SIZE-1:0];

  // Zero padding comes from the bounds check, not from stored border pixels.
  always_comb begin
    int nr;
    int nc;
    win = '0;
    nr  = 0;
    nc  = 0;
    for (int k = 0; k < 9; k++) begin
      nr = int'(pix_addr) / N + NB_DR[k];
      nc = int'(pix_addr) % N + NB_DC[k];
      if (nr >= 0 && nr < N && nc >= 0 && nc < N) win[k] = cur_img[BIT_SIZE'(nr * N + nc)];
    end
  end

  skel_center_mask u_mask (
    .win  (win),
    .sub2 (state_q == SCAN2),
    .del  (del)
  );

  always_comb begin
    state_d   = state_q;
    img0_d    = img0_q;
    img1_d    = img1_q;
    buf_sel_d = buf_sel_q;
    phase_d   = phase_q;
    chg_d     = chg_q;
    addr_d    = addr_q;
    iter_d    = iter_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.we) begin
          state_d = LOAD;
          img0_d  = '0;
          img1_d  = '0;
          addr_d  = '0;
          phase_d = 1'b0;
          iter_d  = '0;
        end
      end
      LOAD: begin
        if (!bus.we) begin
          state_d = SCAN1;
          addr_d  = '0;
          phase_d = 1'b0;
          chg_d   = 1'b0;
        end else begin
          phase_d = ~phase_q;
          // Once the address reaches N*N it stays there, so surplus slots are dropped.
          if (phase_q && addr_q < ADDR_END) begin
            if (buf_sel_q) img1_d[pix_addr] = |bus.data_in;
            else           img0_d[pix_addr] = |bus.data_in;
            addr_d = addr_q + 1'b1;
          end
        end
      end
      SCAN1, SCAN2: begin
        if (addr_q == ADDR_END) begin
          buf_sel_d = ~buf_sel_q;
          addr_d    = '0;
          state_d   = (state_q == SCAN1) ? SCAN2 : CHECK;
        end else begin
          if (buf_sel_q) img0_d[pix_addr] = win[P1] & ~del;
          else           img1_d[pix_addr] = win[P1] & ~del;
          chg_d  = chg_q | del;
          addr_d = addr_q + 1'b1;
        end
      end
      CHECK: begin
        if (iter_q != 8'hFF) iter_d = iter_q + 8'd1;
        if (chg_q) begin
          state_d = SCAN1;
          addr_d  = '0;
          chg_d   = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      img0_q    <= '0;
      img1_q    <= '0;
      buf_sel_q <= 1'b0;
      phase_q   <= 1'b0;
      chg_q     <= 1'b0;
      addr_q    <= '0;
      iter_q    <= '0;
    end else begin
      state_q   <= state_d;
      img0_q    <= img0_d;
      img1_q    <= img1_d;
      buf_sel_q <= buf_sel_d;
      phase_q   <= phase_d;
      chg_q     <= chg_d;
      addr_q    <= addr_d;
      iter_q    <= iter_d;
    end
  end

  assign bus.rd_pixel  = cur_img[bus.rd_addr];
  assign bus.busy      = (state_q == LOAD) || (state_q == SCAN1) || (state_q == SCAN2) ||
                         (state_q == CHECK);
  assign bus.done      = (state_q == DONE);
  assign bus.iter_cnt  = iter_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_skel_main_controller.sv
// Bench for skel_main_controller: loads images, runs thinning and compares against a
// 2-D array Zhang-Suen model, pass count and per-pass latency.
module tb_skel_main_controller;
  import skel_pkg::*;

  logic clk;
  logic rst_n;
  skel_main_controller_if bus ();

  skel_main_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] load_data [80];
  bit m_img [N][N];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.we       = 1'b0;
    bus.data_in  = 8'd0;
    bus.rd_addr  = '0;
    #12;
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- driver tasks ----------------
  // Entry clock, then two clocks per slot with data held; we is left high.
  task automatic load_image(input int slots);
    bus.data_in = load_data[0];
    bus.we      = 1'b1;
    tick();
    for (int s = 0; s < slots; s++) begin
      bus.data_in = load_data[s];
      tick();
      tick();
    end
  endtask

  // First edge with we=0 is the LOAD->SCAN1 transition; cycles counts it as 1.
  task automatic run_to_done(input bit rand_we, output int cycles, output bit ok);
    ok     = 1'b0;
    bus.we = 1'b0;
    tick();
    cycles = 1;
    for (int i = 0; i < 4000; i++) begin
      if (rand_we) bus.we = 1'($urandom_range(0, 1));
      tick();
      cycles++;
      if (bus.done === 1'b1) begin
        bus.we = 1'b0;
        ok     = 1'b1;
        break;
      end
    end
    bus.we = 1'b0;
  endtask

  task automatic read_image(output logic [NPIX-1:0] v);
    for (int a = 0; a < NPIX; a++) begin
      bus.rd_addr = BIT_SIZE'(a);
      #1;
      v[a] = bus.rd_pixel;
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit mget(int r, int c);
    if (r < 0 || r >= N || c < 0 || c >= N) return 1'b0;
    return m_img[r][c];
  endfunction

  task automatic model_load();
    for (int a = 0; a < NPIX; a++) m_img[a / N][a % N] = (load_data[a] != 8'd0);
  endtask

  function automatic logic [NPIX-1:0] model_vec();
    logic [NPIX-1:0] v;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) v[r * N + c] = m_img[r][c];
    return v;
  endfunction

  task automatic model_run(output int passes);
    bit kill [N][N];
    bit nb [8];
    bit changed;
    int b, a;
    bit ok_terms;
    passes = 0;
    do begin
      changed = 1'b0;
      for (int sub = 0; sub < 2; sub++) begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            kill[r][c] = 1'b0;
            if (m_img[r][c]) begin
              nb[0] = mget(r - 1, c);     nb[1] = mget(r - 1, c + 1);
              nb[2] = mget(r, c + 1);     nb[3] = mget(r + 1, c + 1);
              nb[4] = mget(r + 1, c);     nb[5] = mget(r + 1, c - 1);
              nb[6] = mget(r, c - 1);     nb[7] = mget(r - 1, c - 1);
              b = 0;
              a = 0;
              for (int k = 0; k < 8; k++) begin
                b += int'(nb[k]);
                if (!nb[k] && nb[(k + 1) % 8]) a++;
              end
              if (sub == 0) ok_terms = !(nb[0] && nb[2] && nb[4]) && !(nb[2] && nb[4] && nb[6]);
              else          ok_terms = !(nb[0] && nb[2] && nb[6]) && !(nb[0] && nb[4] && nb[6]);
              kill[r][c] = (b >= 2) && (b <= 6) && (a == 1) && ok_terms;
            end
          end
        end
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            if (kill[r][c]) begin
              m_img[r][c] = 1'b0;
              changed     = 1'b1;
            end
      end
      passes++;
    end while (changed);
    if (passes > 255) passes = 255;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [NPIX-1:0] v;
    do_reset();
    read_image(v);
    n_tests += 5;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    if (bus.iter_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_iter got=%0d exp=0", bus.iter_cnt); end
    if (bus.dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", bus.dbg_state, IDLE); end
    if (v !== '0) begin n_fail++; $display("FAIL reset_image got=%h exp=0", v); end
  endtask

  task automatic test_fixed(input string name, input int kind, input int exp_passes);
    logic [NPIX-1:0] v, exp_v;
    int cycles, passes;
    bit ok;
    for (int a = 0; a < 80; a++) load_data[a] = 8'd0;
    if (kind == 1) for (int c = 1; c <= 5; c++) load_data[3 * N + c] = 8'($urandom_range(1, 255));
    if (kind == 2) begin
      load_data[2 * N + 2] = 8'h01; load_data[2 * N + 3] = 8'h80;
      load_data[3 * N + 2] = 8'h33; load_data[3 * N + 3] = 8'hFF;
    end
    model_load();
    if (kind == 2) exp_v = '0;
    else           exp_v = model_vec();
    model_run(passes);
    load_image(NPIX);
    run_to_done(1'b0, cycles, ok);
    read_image(v);
    n_tests += 5;
    if (!ok) begin n_fail++; $display("FAIL %s_done got=timeout exp=done", name); end
    if (bus.iter_cnt !== 8'(exp_passes)) begin n_fail++; $display("FAIL %s_iter got=%0d exp=%0d", name, bus.iter_cnt, exp_passes); end
    if (passes != exp_passes) begin n_fail++; $display("FAIL %s_model_passes got=%0d exp=%0d", name, passes, exp_passes); end
    if (cycles != 131 * exp_passes + 1) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", name, cycles, 131 * exp_passes + 1); end
    if (v !== exp_v) begin n_fail++; $display("FAIL %s_image got=%h exp=%h", name, v, exp_v); end
  endtask

  task automatic test_solid();
    logic [NPIX-1:0] v1, v2;
    int cycles, passes;
    bit ok;
    logic [7:0] it1;
    for (int a = 0; a < 80; a++) load_data[a] = 8'hFF;
    model_load();
    model_run(passes);
    load_image(NPIX);
    run_to_done(1'b0, cycles, ok);
    read_image(v1);
    it1 = bus.iter_cnt;
    n_tests += 5;
    if (!ok) begin n_fail++; $display("FAIL solid_done got=timeout exp=done"); end
    if (it1 !== 8'(passes)) begin n_fail++; $display("FAIL solid_iter got=%0d exp=%0d", it1, passes); end
    if (it1 > 8'd8) begin n_fail++; $display("FAIL solid_iter_bound got=%0d exp<=8", it1); end
    if (v1 !== model_vec()) begin n_fail++; $display("FAIL solid_image got=%h exp=%h", v1, model_vec()); end
    if (v1 == '0) begin n_fail++; $display("FAIL solid_nonempty got=%h exp=nonzero", v1); end
    load_image(NPIX);
    run_to_done(1'b0, cycles, ok);
    read_image(v2);
    n_tests += 2;
    if (v2 !== v1) begin n_fail++; $display("FAIL solid_rerun_image got=%h exp=%h", v2, v1); end
    if (bus.iter_cnt !== it1) begin n_fail++; $display("FAIL solid_rerun_iter got=%0d exp=%0d", bus.iter_cnt, it1); end
  endtask

  task automatic test_random();
    logic [NPIX-1:0] v;
    int cycles, passes, density;
    bit ok;
    for (int t = 0; t < 5; t++) begin
      density = $urandom_range(25, 85);
      for (int a = 0; a < 80; a++)
        load_data[a] = ($urandom_range(0, 99) < density) ? 8'($urandom_range(1, 255)) : 8'd0;
      model_load();
      model_run(passes);
      load_image(NPIX);
      run_to_done(1'b1, cycles, ok);
      read_image(v);
      n_tests += 4;
      if (!ok) begin n_fail++; $display("FAIL rand%0d_done got=timeout exp=done", t); end
      if (bus.iter_cnt !== 8'(passes)) begin n_fail++; $display("FAIL rand%0d_iter got=%0d exp=%0d", t, bus.iter_cnt, passes); end
      if (cycles != 131 * passes + 1) begin n_fail++; $display("FAIL rand%0d_latency got=%0d exp=%0d", t, cycles, 131 * passes + 1); end
      if (v !== model_vec()) begin n_fail++; $display("FAIL rand%0d_image got=%h exp=%h", t, v, model_vec()); end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [NPIX-1:0] v;
    for (int a = 0; a < 80; a++) load_data[a] = 8'hFF;
    load_image(NPIX);
    bus.we = 1'b0;
    tick();
    repeat (70) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests += 4;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    if (bus.iter_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_iter got=%0d exp=0", bus.iter_cnt); end
    read_image(v);
    if (v !== '0) begin n_fail++; $display("FAIL midrst_image got=%h exp=0", v); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_overflow_reload();
    logic [NPIX-1:0] v;
    int cycles, passes;
    bit ok;
    for (int a = 0; a < NPIX; a++)
      load_data[a] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'd0;
    for (int s = NPIX; s < NPIX + 6; s++) load_data[s] = (load_data[s - NPIX] != 8'd0) ? 8'd0 : 8'hA5;
    model_load();
    load_image(NPIX + 6);
    read_image(v);
    n_tests++;
    if (v !== model_vec()) begin n_fail++; $display("FAIL ovf_loaded got=%h exp=%h", v, model_vec()); end
    model_run(passes);
    run_to_done(1'b0, cycles, ok);
    read_image(v);
    n_tests += 2;
    if (v !== model_vec()) begin n_fail++; $display("FAIL ovf_image got=%h exp=%h", v, model_vec()); end
    if (bus.iter_cnt !== 8'(passes)) begin n_fail++; $display("FAIL ovf_iter got=%0d exp=%0d", bus.iter_cnt, passes); end
    bus.data_in = 8'd0;
    bus.we      = 1'b1;
    tick();
    n_tests += 3;
    if (bus.iter_cnt !== 8'd0) begin n_fail++; $display("FAIL reload_iter got=%0d exp=0", bus.iter_cnt); end
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reload_done got=%b exp=0", bus.done); end
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reload_busy got=%b exp=1", bus.busy); end
    bus.we = 1'b0;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fixed("empty", 0, 1);
    test_fixed("hline", 1, 1);
    test_fixed("block", 2, 2);
    test_solid();
    test_random();
    test_reset_mid_scan();
    test_overflow_reload();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
